// File: rtl/br_rs_pkg.sv
// Shared types for the branch reservation station: funct3 encoding, entry and issue bundles,
// plus the CDB snoop helper applied to every waiting source.
package br_rs_pkg;
  localparam int ROB_TAG_W = 4;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    logic                 rdy;
    logic [ROB_TAG_W-1:0] tag;
    logic [31:0]          val;
  } br_src_t;

  typedef struct packed {
    logic                 valid;
    branch_funct3_t       funct3;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic                 pred_taken;
    br_src_t              s1;
    br_src_t              s2;
  } br_rs_entry_t;

  typedef struct packed {
    branch_funct3_t       funct3;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic                 pred_taken;
  } br_issue_t;

  function automatic br_src_t snoop(br_src_t s, logic cv, logic [ROB_TAG_W-1:0] ct,
                                    logic [31:0] cval);
    br_src_t r;
    r = s;
    if (cv && !s.rdy && s.tag == ct) begin
      r.rdy = 1'b1;
      r.val = cval;
    end
    return r;
  endfunction
endpackage

// File: rtl/br_rs_select.sv
// Oldest-first select: lowest set request bit wins.
module br_rs_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/br_rs.sv
// Branch reservation station: compacting age-ordered queue with CDB snoop and a
// registered issue stage feeding the branch comparator.
module br_rs
  import br_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [2:0]       disp_funct3,
  input  logic [TAG_W-1:0] disp_rob_tag,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic             disp_pred_taken,
  input  logic             disp_s1_rdy,
  input  logic             disp_s2_rdy,
  input  logic [TAG_W-1:0] disp_s1_tag,
  input  logic [TAG_W-1:0] disp_s2_tag,
  input  logic [31:0]      disp_s1_val,
  input  logic [31:0]      disp_s2_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_funct3,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [TAG_W-1:0] out_rob_tag,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic             out_pred_taken
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  br_rs_entry_t     ent     [DEPTH];
  br_rs_entry_t     ent_ext [DEPTH+1];
  br_rs_entry_t     ent_n   [DEPTH];
  br_rs_entry_t     dent;
  br_issue_t        out_q, iss;
  logic [CNT_W-1:0] count, count_n, wr_idx;
  logic [DEPTH-1:0] req;
  logic             found, issue, dispatch;
  logic [IDX_W-1:0] sel_idx;

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign dispatch   = disp_valid & disp_ready;
  assign issue      = found & (~out_valid | out_ready);
  assign wr_idx     = count - CNT_W'(issue);
  assign count_n    = count + CNT_W'(dispatch) - CNT_W'(issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      req[i]     = ent[i].valid & ent[i].s1.rdy & ent[i].s2.rdy;
      ent_ext[i] = ent[i];
    end
    ent_ext[DEPTH] = '0;
  end

  br_rs_select #(.N(DEPTH), .IDX_W(IDX_W)) u_sel (
    .req   (req),
    .found (found),
    .idx   (sel_idx)
  );

  always_comb begin
    iss.funct3     = ent[sel_idx].funct3;
    iss.a          = ent[sel_idx].s1.val;
    iss.b          = ent[sel_idx].s2.val;
    iss.rob_tag    = ent[sel_idx].rob_tag;
    iss.pc         = ent[sel_idx].pc;
    iss.imm        = ent[sel_idx].imm;
    iss.pred_taken = ent[sel_idx].pred_taken;
  end

  // Incoming entry sees the same-cycle CDB so it never misses a broadcast.
  always_comb begin
    dent.valid      = 1'b1;
    dent.funct3     = branch_funct3_t'(disp_funct3);
    dent.rob_tag    = disp_rob_tag;
    dent.pc         = disp_pc;
    dent.imm        = disp_imm;
    dent.pred_taken = disp_pred_taken;
    dent.s1         = snoop('{rdy: disp_s1_rdy, tag: disp_s1_tag, val: disp_s1_val},
                            cdb_valid, cdb_tag, cdb_val);
    dent.s2         = snoop('{rdy: disp_s2_rdy, tag: disp_s2_tag, val: disp_s2_val},
                            cdb_valid, cdb_tag, cdb_val);
  end

  // Compact above the issued slot, snoop the CDB, then drop in the dispatched entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i]    = (issue && IDX_W'(i) >= sel_idx) ? ent_ext[i+1] : ent[i];
      ent_n[i].s1 = snoop(ent_n[i].s1, cdb_valid, cdb_tag, cdb_val);
      ent_n[i].s2 = snoop(ent_n[i].s2, cdb_valid, cdb_tag, cdb_val);
      if (dispatch && CNT_W'(i) == wr_idx) ent_n[i] = dent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_n[i];
      count <= count_n;
      if (issue) begin
        out_valid <= 1'b1;
        out_q     <= iss;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_funct3     = out_q.funct3;
  assign out_a          = out_q.a;
  assign out_b          = out_q.b;
  assign out_rob_tag    = out_q.rob_tag;
  assign out_pc         = out_q.pc;
  assign out_imm        = out_q.imm;
  assign out_pred_taken = out_q.pred_taken;
endmodule

// File: tb/tb_br_rs.sv
// Directed, table-driven bench for br_rs with hand sequences for flush and async reset.
module tb_br_rs;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        disp_valid = 1'b0, disp_ready;
  logic [2:0]  disp_funct3 = '0;
  logic [3:0]  disp_rob_tag = '0;
  logic [31:0] disp_pc = '0, disp_imm = '0;
  logic        disp_pred_taken = 1'b0;
  logic        disp_s1_rdy = 1'b0, disp_s2_rdy = 1'b0;
  logic [3:0]  disp_s1_tag = '0, disp_s2_tag = '0;
  logic [31:0] disp_s1_val = '0, disp_s2_val = '0;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_val = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [2:0]  out_funct3;
  logic [31:0] out_a, out_b, out_pc, out_imm;
  logic [3:0]  out_rob_tag;
  logic        out_pred_taken;

  int n_chk = 0, n_fail = 0;

  br_rs #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_funct3(disp_funct3),
    .disp_rob_tag(disp_rob_tag), .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_pred_taken(disp_pred_taken), .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy),
    .disp_s1_tag(disp_s1_tag), .disp_s2_tag(disp_s2_tag),
    .disp_s1_val(disp_s1_val), .disp_s2_val(disp_s2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_funct3(out_funct3),
    .out_a(out_a), .out_b(out_b), .out_rob_tag(out_rob_tag),
    .out_pc(out_pc), .out_imm(out_imm), .out_pred_taken(out_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [2:0]  f3;
    logic [3:0]  tag;
    logic        s1r;
    logic [3:0]  s1t;
    logic [31:0] s1v;
    logic        s2r;
    logic [3:0]  s2t;
    logic [31:0] s2v;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cval;
    logic        ordy;
    logic        eov;
    logic [3:0]  etag;
    logic [2:0]  ef3;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        edr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic dv, logic [2:0] f3, logic [3:0] tag,
                             logic s1r, logic [3:0] s1t, logic [31:0] s1v,
                             logic s2r, logic [3:0] s2t, logic [31:0] s2v,
                             logic cv, logic [3:0] ct, logic [31:0] cval, logic ordy,
                             logic eov, logic [3:0] etag, logic [2:0] ef3,
                             logic [31:0] ea, logic [31:0] eb, logic edr);
    vec_t r;
    r.dv = dv; r.f3 = f3; r.tag = tag; r.s1r = s1r; r.s1t = s1t; r.s1v = s1v;
    r.s2r = s2r; r.s2t = s2t; r.s2v = s2v; r.cv = cv; r.ct = ct; r.cval = cval;
    r.ordy = ordy; r.eov = eov; r.etag = etag; r.ef3 = ef3; r.ea = ea; r.eb = eb; r.edr = edr;
    return r;
  endfunction

  task automatic check(string name, int row, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    disp_valid = x.dv; disp_funct3 = x.f3; disp_rob_tag = x.tag;
    disp_pc = {24'h0, 4'h1, x.tag, 2'b00}; disp_imm = 32'h10;
    disp_s1_rdy = x.s1r; disp_s1_tag = x.s1t; disp_s1_val = x.s1v;
    disp_s2_rdy = x.s2r; disp_s2_tag = x.s2t; disp_s2_val = x.s2v;
    cdb_valid = x.cv; cdb_tag = x.ct; cdb_val = x.cval; out_ready = x.ordy;
  endtask

  task automatic rdy_disp(logic [3:0] tag, logic [31:0] a, logic ordy);
    drive(v(1, 3'd0, tag, 1, 0, a, 1, 0, a + 1, 0, 0, 0, ordy, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic idle(logic ordy);
    drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // dv f3 tag | s1r s1t s1v | s2r s2t s2v | cv ct cval | ordy || eov etag ef3 ea eb edr
    vecs.push_back(v(1, 0, 1,  1, 0, 5,  1, 0, 5,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 1, 0, 5, 5, 1));
    vecs.push_back(v(1, 4, 2,  0, 3, 0,  1, 0, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 3, 32'hFFFFFFFF, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 2, 4, 32'hFFFFFFFF, 0, 1));
    vecs.push_back(v(1, 1, 4,  0, 7, 0,  1, 0, 3,  1, 7, 32'h10, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 4, 1, 32'h10, 3, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    // Fill with output stalled; fifth dispatch is dropped.
    vecs.push_back(v(1, 5, 8,  1, 0, 10, 1, 0, 11, 0, 0, 0,  0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 5, 9,  1, 0, 20, 1, 0, 21, 0, 0, 0,  0,  1, 8, 5, 10, 11, 1));
    vecs.push_back(v(1, 5, 10, 1, 0, 30, 1, 0, 31, 0, 0, 0,  0,  1, 8, 5, 10, 11, 1));
    vecs.push_back(v(1, 5, 11, 1, 0, 40, 1, 0, 41, 0, 0, 0,  0,  1, 8, 5, 10, 11, 1));
    vecs.push_back(v(1, 5, 12, 1, 0, 50, 1, 0, 51, 0, 0, 0,  0,  1, 8, 5, 10, 11, 0));
    vecs.push_back(v(1, 5, 13, 1, 0, 60, 1, 0, 61, 0, 0, 0,  0,  1, 8, 5, 10, 11, 0));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 9, 5, 20, 21, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 10, 5, 30, 31, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 11, 5, 40, 41, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 12, 5, 50, 51, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    // Younger ready entry bypasses two waiting ones, which keep their order.
    vecs.push_back(v(1, 0, 1,  0, 5, 0,  1, 0, 32'h11, 0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 2,  0, 6, 0,  1, 0, 32'h22, 0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 7, 3,  1, 0, 32'h33, 1, 0, 32'h34, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 3, 7, 32'h33, 32'h34, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 6, 32'h66, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 5, 32'h55, 1,  1, 2, 0, 32'h66, 32'h22, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 1, 0, 32'h55, 32'h11, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    // Both sources waiting on the same producer.
    vecs.push_back(v(1, 6, 5,  0, 9, 0,  0, 9, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 9, 32'h99, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 5, 6, 32'h99, 32'h99, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    // Back-to-back: dispatch lands at count-1 while entry 0 issues.
    vecs.push_back(v(1, 0, 1,  1, 0, 1,  1, 0, 1,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 2,  1, 0, 2,  1, 0, 2,  0, 0, 0,  1,  1, 1, 0, 1, 1, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  1, 2, 1, 2, 2, 1));
    vecs.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", -1, 32'(out_valid), 32'd0);
    check("reset_out_a", -1, out_a, 32'd0);
    check("reset_out_tag", -1, 32'(out_rob_tag), 32'd0);
    check("reset_disp_ready", -1, 32'(disp_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk) drive(vecs[r]);
      @(posedge clk);
      #1;
      check("out_valid", r, 32'(out_valid), 32'(vecs[r].eov));
      check("disp_ready", r, 32'(disp_ready), 32'(vecs[r].edr));
      if (vecs[r].eov) begin
        check("out_rob_tag", r, 32'(out_rob_tag), 32'(vecs[r].etag));
        check("out_funct3", r, 32'(out_funct3), 32'(vecs[r].ef3));
        check("out_a", r, out_a, vecs[r].ea);
        check("out_b", r, out_b, vecs[r].eb);
        check("out_pc", r, out_pc, {24'h0, 4'h1, vecs[r].etag, 2'b00});
      end
    end

    // Flush with three queued entries, a held output and a concurrent dispatch.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk) rdy_disp(4'(k), 32'(k * 16), 1'b0);
      @(posedge clk);
    end
    #1;
    check("preflush_out_valid", 100, 32'(out_valid), 32'd1);
    check("preflush_out_tag", 100, 32'(out_rob_tag), 32'd1);
    @(negedge clk) begin
      rdy_disp(4'd9, 32'h90, 1'b0);
      flush = 1'b1;
    end
    @(posedge clk);
    #1;
    check("flush_out_valid", 101, 32'(out_valid), 32'd0);
    check("flush_disp_ready", 101, 32'(disp_ready), 32'd1);
    @(negedge clk) begin
      flush = 1'b0;
      idle(1'b1);
    end
    @(posedge clk);
    #1;
    check("postflush_empty", 102, 32'(out_valid), 32'd0);

    // Async reset mid-operation clears without waiting for a clock edge.
    @(negedge clk) rdy_disp(4'd6, 32'h77, 1'b0);
    @(negedge clk) idle(1'b0);
    @(posedge clk);
    #1;
    check("prereset_out_valid", 103, 32'(out_valid), 32'd1);
    check("prereset_out_a", 103, out_a, 32'h77);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 104, 32'(out_valid), 32'd0);
    check("async_rst_out_a", 104, out_a, 32'd0);
    check("async_rst_disp_ready", 104, 32'(disp_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    idle(1'b1);
    @(posedge clk);
    #1;
    check("postreset_empty", 105, 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/br_rs.md
Name: br_rs

Overview:
- Branch reservation station: buffers dispatched conditional branches until both operands are available.
- Snoops the CDB for operands still in flight and issues the oldest ready entry into a registered output stage.
- The output stage drives the branch comparator (load, funct3, a, b) and carries ROB tag, PC, immediate and prediction to branch resolution.
- Sits between dispatch/rename and the comparator.

Parameters:
- DEPTH, 4, number of entries (≥2).
- TAG_W, 4, ROB tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  mispredict flush; clears station and output stage.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept.
- disp_funct3  in  3  sched_structs::branch_funct3_t.
- disp_rob_tag  in  TAG_W  ROB tag of branch.
- disp_pc  in  32  branch PC.
- disp_imm  in  32  sign-extended B-immediate.
- disp_pred_taken  in  1  front-end prediction.
- disp_s1_rdy, disp_s2_rdy  in  1 each  operand already valid.
- disp_s1_tag, disp_s2_tag  in  TAG_W each  producer tag when not ready.
- disp_s1_val, disp_s2_val  in  32 each  operand value when ready.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  TAG_W  CDB tag.
- cdb_val  in  32  CDB value.
- out_valid  out  1  issue-stage valid; drives comparator load.
- out_ready  in  1  downstream accepts.
- out_funct3  out  3  to comparator.
- out_a, out_b  out  32 each  operands to comparator.
- out_rob_tag  out  TAG_W  ROB tag.
- out_pc, out_imm  out  32 each  for target computation.
- out_pred_taken  out  1  prediction.

Behaviour:
- Reset (async, rst_n=0): all entry valids 0, count 0, out_valid 0, all out_* data 0. disp_ready is 1 after reset.
- Storage: compacting age-ordered queue; entry 0 is oldest; valid entries are contiguous from 0.
- disp_ready = (count < DEPTH), from registered count only. No same-cycle credit from an issuing entry.
- Dispatch (disp_valid & disp_ready): entry is written at index count, or count-1 if an issue occurs the same cycle.
- CDB capture, every cycle, for each valid entry: a source with rdy=0 and tag==cdb_tag takes cdb_val and sets rdy=1.
- Dispatch/CDB same cycle: a dispatched source with rdy=0 whose tag==cdb_tag is written ready with cdb_val.
- Issue eligibility: entry valid and both rdy flags set in registered state. A CDB wakeup makes an entry eligible the next cycle (1-cycle wakeup-to-select).
- Select: lowest-index eligible entry, i.e. the oldest.
- Issue fires when an eligible entry exists and (!out_valid | out_ready).
- On issue: selected entry moves into the output registers, out_valid=1, and entries above it shift down one slot. CDB capture applies to the shifted entries in the same cycle.
- Output stage: holds all data stable while out_valid & !out_ready. When out_valid & out_ready and nothing issues, out_valid clears next cycle.
- Latency: a dispatch with both operands ready gives out_valid on the next clock edge (1 cycle).
- Throughput: one issue per cycle when out_ready=1.
- Flush (synchronous, highest priority): all entries invalid, count=0, out_valid=0. Dispatch, issue and CDB effects that cycle are discarded.
- Empty: no issue; out_valid follows the handshake.
- Full: disp_ready=0. Dispatch attempts while full are ignored.
- Count stays within 0..DEPTH. Width is $clog2(DEPTH+1).
- Duplicate sources (s1_tag==s2_tag) are both woken by one broadcast.

Decomposition:
- sched_structs gains:
  - br_rs_entry_t: valid, funct3, rob_tag, pc, imm, pred_taken, s1/s2 {rdy, tag, val}.
  - br_issue_t: the out_* bundle.
- TAG_W is taken from the package's ROB tag constant where one exists.
- One sub-module, br_rs_select: combinational oldest-eligible priority encoder over DEPTH request bits, returning found and index.

Test Plan:
- Dispatch beq, s1=s2=5 both ready, out_ready=1 -> next cycle out_valid=1, out_funct3=beq, out_a=out_b=5, rob tag matches. Comparator br_en=1.
- Dispatch blt, s1 tag 3 not ready, s2=0 ready. CDB tag 3 val 0xFFFFFFFF two cycles later -> issue the cycle after the CDB with out_a=0xFFFFFFFF. Comparator br_en=1.
- Fill DEPTH=4 entries, out_ready=0 -> disp_ready=0 after the 4th. Fifth disp_valid is dropped. Output holds entry 0 stable. Raising out_ready drains in dispatch order.
- Dispatch with s1 tag 7 while cdb_valid, tag 7, val 0x10 the same cycle -> entry ready and issues next cycle with out_a=0x10.
- Entries 0 and 1 waiting, entry 2 ready -> entry 2 issues first, and entries 0 and 1 keep their order after compaction.
- Flush asserted with 3 entries and out_valid=1 (same cycle as a dispatch) -> next cycle count=0, out_valid=0, disp_ready=1. rst_n pulsed mid-operation clears immediately, asynchronously.
